// File: rtl/score_display.sv
// Score display: converts a binary score to BCD by sequential double dabble
// and multiplexes the four BCD digits onto a common-anode 7-segment display.
module score_display #(
    parameter int REFRESH_DIV = 100_000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [13:0] i_score,
    input  logic        i_valid,
    output logic        o_busy,
    output logic [15:0] o_bcd,
    output logic [3:0]  o_an,
    output logic [6:0]  o_seg
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state;
    state_t        state_next;
    logic [13:0]   bin;
    logic [15:0]   work;
    logic [15:0]   work_adj;
    logic [15:0]   bcd;
    logic [15:0]   bcd_next;
    logic [3:0]    iter;
    logic          accept;
    logic          last;
    logic [CW-1:0] ref_cnt;
    logic          ref_wrap;
    logic [1:0]    digit;
    logic [1:0]    digit_next;
    logic [3:0]    an;
    logic [6:0]    seg;
    logic [6:0]    seg_next;
    logic [6:0]    glyph;
    logic [3:0]    nib;
    logic          blank;

    // DONE also accepts so that a held i_valid restarts without an idle gap
    assign accept = i_valid && (state == IDLE || state == DONE);
    assign last   = (iter == 4'd14);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SHIFT;
            SHIFT:   if (last) state_next = DONE;
            DONE:    state_next = accept ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The SHIFT cycle right after the accept edge has iter==0 and is not yet busy
    always_comb begin
        o_busy   = (state == SHIFT) && (iter != 4'd0);
        bcd_next = bcd;
        if (state == SHIFT && last) bcd_next = work;
    end

    always_comb begin
        work_adj = work;
        for (int i = 0; i < 4; i++) begin
            if (work[4*i +: 4] >= 4'd5) work_adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bin  <= '0;
            work <= '0;
            iter <= '0;
            bcd  <= '0;
        end else begin
            bcd <= bcd_next;
            if (accept) begin
                bin  <= (i_score > 14'd9999) ? 14'd9999 : i_score;
                work <= '0;
                iter <= '0;
            end else if (state == SHIFT && !last) begin
                work <= (work_adj << 1) | {15'd0, bin[13]};
                bin  <= {bin[12:0], 1'b0};
                iter <= iter + 4'd1;
            end
        end
    end

    assign ref_wrap   = (ref_cnt == REF_LAST);
    assign digit_next = ref_wrap ? digit + 2'd1 : digit;

    // Look ahead to the next digit and BCD value so the registered outputs stay aligned
    always_comb begin
        nib = bcd_next[{digit_next, 2'b00} +: 4];
        case (digit_next)
            2'd1:    blank = (bcd_next[15:4] == 12'd0);
            2'd2:    blank = (bcd_next[15:8] == 8'd0);
            2'd3:    blank = (bcd_next[15:12] == 4'd0);
            default: blank = 1'b0;
        endcase
        case (nib)
            4'd0:    glyph = 7'h40;
            4'd1:    glyph = 7'h79;
            4'd2:    glyph = 7'h24;
            4'd3:    glyph = 7'h30;
            4'd4:    glyph = 7'h19;
            4'd5:    glyph = 7'h12;
            4'd6:    glyph = 7'h02;
            4'd7:    glyph = 7'h78;
            4'd8:    glyph = 7'h00;
            4'd9:    glyph = 7'h10;
            default: glyph = 7'h7F;
        endcase
        seg_next = blank ? 7'h7F : glyph;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ref_cnt <= '0;
            digit   <= 2'd0;
            an      <= 4'b1110;
            seg     <= 7'h40;
        end else begin
            ref_cnt <= ref_wrap ? '0 : ref_cnt + CW'(1);
            digit   <= digit_next;
            an      <= ~(4'b0001 << digit_next);
            seg     <= seg_next;
        end
    end

    assign o_bcd = bcd;
    assign o_an  = an;
    assign o_seg = seg;
endmodule

// File: tb/tb_score_display.sv
// Bench for score_display: a timeline model of the converter and display,
// driven by directed scenarios and a randomized back-to-back sweep.
module tb_score_display;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0;
    logic [13:0] score = '0;
    logic        busy;
    logic [15:0] bcd;
    logic [3:0]  an;
    logic [6:0]  seg;

    int tests = 0;
    int failures = 0;

    // Model: cycles since accept (-1 when idle), latched value, shown value, cycles since reset
    int m_k = -1;
    int m_latched = 0;
    int m_shown = 0;
    int m_cyc = 0;

    always #5 clk = ~clk;

    score_display #(.REFRESH_DIV(4)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_score(score),
        .i_valid(valid),
        .o_busy (busy),
        .o_bcd  (bcd),
        .o_an   (an),
        .o_seg  (seg)
    );

    function automatic int clampModel(input int v);
        return (v > 9999) ? 9999 : v;
    endfunction

    function automatic logic [15:0] bcdModel(input int n);
        return 16'(((n / 1000) % 10) * 4096 + ((n / 100) % 10) * 256 + ((n / 10) % 10) * 16 + n % 10);
    endfunction

    function automatic logic [6:0] glyphModel(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] segModel(input int n, input int d);
        int p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        if (d > 0 && n < p) return 7'h7F;
        return glyphModel((n / p) % 10);
    endfunction

    function automatic logic [3:0] anModel(input int d);
        logic [3:0] a = 4'hF;
        a[d] = 1'b0;
        return a;
    endfunction

    function automatic int digitModel();
        return (m_cyc / 4) % 4;
    endfunction

    task automatic modelReset();
        m_k = -1;
        m_shown = 0;
        m_cyc = 0;
    endtask

    task automatic applyStimulus(input int s, input logic v);
        score = 14'(s);
        valid = v;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".busy"}, {15'd0, busy}, {15'd0, (m_k >= 1 && m_k <= 14)});
        checkOutput({tag, ".bcd"}, bcd, bcdModel(m_shown));
        checkOutput({tag, ".an"}, {12'd0, an}, {12'd0, anModel(digitModel())});
        checkOutput({tag, ".seg"}, {9'd0, seg}, {9'd0, segModel(m_shown, digitModel())});
    endtask

    // One clock edge: the model sees the same inputs the DUT samples, then outputs settle
    task automatic step();
        logic r;
        logic v;
        int   s;
        r = rst;
        v = valid;
        s = int'(score);
        @(posedge clk);
        if (r) begin
            modelReset();
        end else begin
            m_cyc++;
            if (m_k >= 0 && m_k < 15) begin
                m_k++;
                if (m_k == 15) m_shown = m_latched;
            end else if (v) begin
                m_k = 0;
                m_latched = clampModel(s);
            end else begin
                m_k = -1;
            end
        end
        #1;
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step();
            checkAll(tag);
        end
    endtask

    initial begin
        int busy_cycles;
        int d;
        int val;
        logic [3:0] an_exp;
        logic [6:0] seg_exp;

        #2 rst = 1'b1;
        #1;
        modelReset();
        checkAll("por");
        step();
        step();
        rst = 1'b0;
        checkAll("rst_rel");

        // Conversion latency for 1234
        applyStimulus(1234, 1'b1);
        step();
        checkAll("lat");
        busy_cycles = int'(busy);
        applyStimulus(1234, 1'b0);
        for (int i = 0; i < 15; i++) begin
            step();
            checkAll("lat");
            busy_cycles += int'(busy);
        end
        checkOutput("lat.busy_cycles", 16'(busy_cycles), 16'd14);
        checkOutput("lat.result", bcd, 16'h1234);

        // Clamp, with a request during busy that must be dropped
        applyStimulus(12000, 1'b1);
        step();
        checkAll("clamp");
        applyStimulus(12000, 1'b0);
        run(4, "clamp");
        applyStimulus(42, 1'b1);
        step();
        checkAll("drop");
        applyStimulus(42, 1'b0);
        run(30, "drop");
        checkOutput("clamp.result", bcd, 16'h9999);

        // Digit multiplexing and leading-zero blanking for 0007
        applyStimulus(7, 1'b1);
        step();
        applyStimulus(7, 1'b0);
        run(16, "mux_conv");
        for (int i = 0; i < 16; i++) begin
            step();
            checkAll("mux");
            d = digitModel();
            case (d)
                0: begin an_exp = 4'b1110; seg_exp = 7'h78; end
                1: begin an_exp = 4'b1101; seg_exp = 7'h7F; end
                2: begin an_exp = 4'b1011; seg_exp = 7'h7F; end
                default: begin an_exp = 4'b0111; seg_exp = 7'h7F; end
            endcase
            checkOutput("mux.an_const", {12'd0, an}, {12'd0, an_exp});
            checkOutput("mux.seg_const", {9'd0, seg}, {9'd0, seg_exp});
        end

        // Reset asserted mid-cycle at iteration 7 of a 5678 conversion
        applyStimulus(5678, 1'b1);
        step();
        checkAll("mid");
        applyStimulus(5678, 1'b0);
        run(7, "mid");
        #3 rst = 1'b1;
        #1;
        modelReset();
        checkOutput("async.bcd", bcd, 16'h0000);
        checkOutput("async.busy", {15'd0, busy}, 16'd0);
        checkOutput("async.an", {12'd0, an}, 16'b1110);
        checkOutput("async.seg", {9'd0, seg}, 16'h40);
        applyStimulus(305, 1'b1);
        step();
        checkAll("in_rst");
        rst = 1'b0;
        step();
        checkAll("post_rst");
        applyStimulus(305, 1'b0);
        run(15, "post_rst");
        checkOutput("post_rst.result", bcd, 16'h0305);
        for (int i = 0; i < 16; i++) begin
            step();
            checkAll("d0305");
            d = digitModel();
            case (d)
                0: seg_exp = 7'h12;
                1: seg_exp = 7'h40;
                2: seg_exp = 7'h30;
                default: seg_exp = 7'h7F;
            endcase
            checkOutput("d0305.seg_const", {9'd0, seg}, {9'd0, seg_exp});
        end

        // Back-to-back sweep with valid held high; only the accept cycle's score matters
        for (int conv = 0; conv < 44; conv++) begin
            if (conv == 0) val = 0;
            else if (conv == 39) val = 9999;
            else if (conv < 40) val = clampModel(conv * 250 + int'($urandom_range(0, 249)));
            else val = int'($urandom_range(10000, 16383));
            for (int k = 0; k < 16; k++) begin
                applyStimulus((k == 0) ? val : int'($urandom_range(0, 16383)), 1'b1);
                step();
                checkAll("b2b");
            end
        end
        applyStimulus(0, 1'b0);
        run(20, "b2b_tail");

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
